// File: rtl/sram_march_bist.sv
// March C- BIST controller for a single-port SRAM BIST port group.
// Runs all six march elements over the full array. It reports pass/fail,
// a saturating error count and the details of the first mismatch.
module sram_march_bist #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1,
  parameter int ERR_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data,
  output logic              bist_en,
  output logic              bist_men,
  output logic              bist_wen,
  output logic              bist_ren,
  output logic [ADDR_W-1:0] bist_addr,
  output logic [DATA_W-1:0] bist_din,
  output logic [DATA_W-1:0] bist_bm,
  input  logic [DATA_W-1:0] bist_dout
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // One in-flight read: expected data plus where it came from.
  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] exp;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        elem;
  } cmp_t;

  localparam int                DW    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [ADDR_W-1:0] A_MAX = {ADDR_W{1'b1}};
  localparam logic [DATA_W-1:0] D_ONE = {DATA_W{1'b1}};
  localparam logic [ERR_W-1:0]  E_MAX = {ERR_W{1'b1}};

  state_t             r_state, w_state_nx;
  logic [2:0]         r_elem, w_elem_nx;
  logic [ADDR_W-1:0]  r_addr, w_addr_nx;
  logic               r_ph, w_ph_nx;
  logic [DW-1:0]      r_dcnt;
  cmp_t [READ_LAT:0]  r_pipe;
  logic               w_start_ok, w_run_nx, w_busy_nx, w_rd_nx, w_mis;
  logic [ERR_W-1:0]   w_err_nx;

  // Element 0 is write-only, element 5 read-only; others are read then write.
  function automatic logic f_is_rd(input logic [2:0] e, input logic ph);
    return (e != 3'd0) && !ph;
  endfunction
  function automatic logic f_last_ph(input logic [2:0] e, input logic ph);
    return (e == 3'd0) || (e == 3'd5) || ph;
  endfunction
  function automatic logic f_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction
  function automatic logic [DATA_W-1:0] f_rd_val(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? D_ONE : '0;
  endfunction
  function automatic logic [DATA_W-1:0] f_wr_val(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? D_ONE : '0;
  endfunction

  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_run_nx   = (w_state_nx == S_RUN);
  assign w_busy_nx  = (w_state_nx == S_RUN) || (w_state_nx == S_DRAIN);
  assign w_rd_nx    = f_is_rd(w_elem_nx, w_ph_nx);
  assign w_mis      = r_pipe[READ_LAT].vld && (bist_dout != r_pipe[READ_LAT].exp);
  assign w_err_nx   = (w_mis && (err_count != E_MAX)) ? err_count + 1'b1 : err_count;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // Next state and next march op (element, address, op phase).
  always_comb begin
    w_state_nx = r_state;
    w_elem_nx  = r_elem;
    w_addr_nx  = r_addr;
    w_ph_nx    = r_ph;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nx = S_RUN;
          w_elem_nx  = 3'd0;
          w_addr_nx  = '0;
          w_ph_nx    = 1'b0;
        end
      end
      S_RUN: begin
        if (!f_last_ph(r_elem, r_ph)) begin
          w_ph_nx = 1'b1;
        end else begin
          w_ph_nx = 1'b0;
          if (r_addr == (f_down(r_elem) ? '0 : A_MAX)) begin
            if (r_elem == 3'd5) begin
              w_state_nx = S_DRAIN;
            end else begin
              w_elem_nx = r_elem + 3'd1;
              w_addr_nx = f_down(r_elem + 3'd1) ? A_MAX : '0;
            end
          end else begin
            w_addr_nx = f_down(r_elem) ? r_addr - 1'b1 : r_addr + 1'b1;
          end
        end
      end
      S_DRAIN: if (r_dcnt == DW'(READ_LAT - 1)) w_state_nx = S_DONE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Op counters, registered strobes, compare pipeline and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_elem    <= '0;
      r_addr    <= '0;
      r_ph      <= 1'b0;
      r_dcnt    <= '0;
      r_pipe    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
      bist_en   <= 1'b0;
      bist_men  <= 1'b0;
      bist_wen  <= 1'b0;
      bist_ren  <= 1'b0;
      bist_addr <= '0;
      bist_din  <= '0;
      bist_bm   <= '0;
    end else begin
      r_elem    <= w_elem_nx;
      r_addr    <= w_addr_nx;
      r_ph      <= w_ph_nx;
      r_dcnt    <= (r_state == S_DRAIN) ? r_dcnt + DW'(1) : '0;
      busy      <= w_busy_nx;
      bist_en   <= w_busy_nx;
      bist_bm   <= w_busy_nx ? D_ONE : '0;
      bist_men  <= w_run_nx;
      bist_wen  <= w_run_nx && !w_rd_nx;
      bist_ren  <= w_run_nx && w_rd_nx;
      bist_addr <= w_run_nx ? w_addr_nx : '0;
      bist_din  <= (w_run_nx && !w_rd_nx) ? f_wr_val(w_elem_nx) : '0;
      // Stage 0 launches with the read strobe; the last stage lines up with dout.
      r_pipe[0] <= '{vld: w_run_nx && w_rd_nx, exp: f_rd_val(w_elem_nx),
                     addr: w_addr_nx, elem: w_elem_nx};
      for (int i = 1; i <= READ_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      if (w_start_ok) begin
        done      <= 1'b0;
        pass      <= 1'b0;
        err_count <= '0;
        fail_addr <= '0;
        fail_elem <= '0;
        fail_data <= '0;
      end else begin
        err_count <= w_err_nx;
        if (w_mis && (err_count == '0)) begin
          fail_addr <= r_pipe[READ_LAT].addr;
          fail_elem <= r_pipe[READ_LAT].elem;
          fail_data <= bist_dout;
        end
        // The final compare lands on this same edge, so use the updated count.
        if ((r_state == S_DRAIN) && (w_state_nx == S_DONE)) begin
          done <= 1'b1;
          pass <= (w_err_nx == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: faulty SRAM model plus an algorithmic March C-
// reference that predicts error count and first failure for each run.
module tb_sram_march_bist;
  localparam int AW = 4, DW = 8, RL = 1, EW = 4;
  localparam int DEPTH = 1 << AW, NOPS = 10 * DEPTH;
  localparam int EMAX = (1 << EW) - 1;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic          busy, done, pass, bist_en, bist_men, bist_wen, bist_ren;
  logic [EW-1:0] err_count;
  logic [AW-1:0] fail_addr, bist_addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_data, bist_din, bist_bm, bist_dout = '0;

  sram_march_bist #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .ERR_W(EW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_addr(fail_addr), .fail_elem(fail_elem),
    .fail_data(fail_data), .bist_en(bist_en), .bist_men(bist_men),
    .bist_wen(bist_wen), .bist_ren(bist_ren), .bist_addr(bist_addr),
    .bist_din(bist_din), .bist_bm(bist_bm), .bist_dout(bist_dout));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int busy_cyc, strobe_cyc, bad_cyc;

  // Fault description shared by the SRAM model and the reference.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] s_and [DEPTH];
  logic [DW-1:0] s_or  [DEPTH];
  bit cpl_en;
  int cpl_agg, cpl_vic;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] stuck(input int a, input logic [DW-1:0] d);
    return (d & s_and[a]) | s_or[a];
  endfunction

  // Faulty single-port SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (bist_men) begin
      if (bist_wen) begin
        mem[bist_addr] = stuck(int'(bist_addr), (mem[bist_addr] & ~bist_bm) | (bist_din & bist_bm));
        if (cpl_en && int'(bist_addr) == cpl_agg) mem[cpl_vic] = stuck(cpl_vic, ~mem[cpl_vic]);
      end else if (bist_ren) begin
        bist_dout <= mem[bist_addr];
      end
    end
  end

  // Per-cycle observations during a run.
  always @(negedge clk) begin
    if (busy) busy_cyc++;
    if (bist_men) strobe_cyc++;
    if ((bist_en !== busy) || (bist_bm !== (busy ? 8'hFF : 8'h00)) ||
        (!busy && (bist_wen || bist_ren))) bad_cyc++;
  end

  function automatic logic [63:0] all_outs();
    return {busy, done, pass, err_count, fail_addr, fail_elem, fail_data, bist_en,
            bist_men, bist_wen, bist_ren, bist_addr, bist_din, bist_bm};
  endfunction

  // March C- applied to a copy of the current memory with the same faults.
  task automatic ref_model(output int errs, output int faddr, output int felem,
                           output int fdata);
    logic [DW-1:0] rm [DEPTH];
    int a, nops;
    logic [DW-1:0] rv, wv;
    for (int i = 0; i < DEPTH; i++) rm[i] = mem[i];
    errs = 0; faddr = 0; felem = 0; fdata = 0;
    for (int e = 0; e < 6; e++) begin
      rv   = (e == 2 || e == 4) ? 8'hFF : 8'h00;
      wv   = (e == 1 || e == 3) ? 8'hFF : 8'h00;
      nops = (e == 0 || e == 5) ? 1 : 2;
      for (int s = 0; s < DEPTH; s++) begin
        a = (e == 3 || e == 4) ? DEPTH - 1 - s : s;
        for (int j = 0; j < nops; j++) begin
          if (e != 0 && j == 0) begin
            if (rm[a] !== rv) begin
              if (errs == 0) begin faddr = a; felem = e; fdata = int'(rm[a]); end
              errs++;
            end
          end else begin
            rm[a] = stuck(a, wv);
            if (cpl_en && a == cpl_agg) rm[cpl_vic] = stuck(cpl_vic, ~rm[cpl_vic]);
          end
        end
      end
    end
    if (errs > EMAX) errs = EMAX;
  endtask

  task automatic clear_faults();
    for (int i = 0; i < DEPTH; i++) begin s_and[i] = 8'hFF; s_or[i] = 8'h00; end
    cpl_en = 1'b0; cpl_agg = 0; cpl_vic = 0;
  endtask

  // One test run; abort_at>0 pulses reset at that cycle, repulse re-hits start.
  task automatic run_once(input string tag, input int abort_at, input bit repulse);
    int errs, faddr, felem, fdata, c;
    ref_model(errs, faddr, felem, fdata);
    @(negedge clk); start = 1'b1;
    #1 busy_cyc = 0; strobe_cyc = 0; bad_cyc = 0;
    @(negedge clk); start = 1'b0;
    chk({tag, "_busy0"}, {busy, done, pass, err_count, fail_addr}, {1'b1, 1'b0, 1'b0, 4'h0, 4'h0});
    c = 1;
    while (!done && c < 400) begin
      start = repulse && (c == 10 || c == 100);
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1 chk({tag, "_abort_zero"}, all_outs(), 64'h0);
        @(negedge clk); rst_n = 1'b1;
        return;
      end
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_cyc"}, busy_cyc, NOPS + RL);
    chk({tag, "_strobes"}, strobe_cyc, NOPS);
    chk({tag, "_en_bm"}, bad_cyc, 0);
    chk({tag, "_pass"}, pass, errs == 0);
    chk({tag, "_errs"}, err_count, errs);
    chk({tag, "_faddr"}, fail_addr, faddr);
    chk({tag, "_felem"}, fail_elem, felem);
    chk({tag, "_fdata"}, fail_data, fdata);
    repeat (3) @(negedge clk);
    chk({tag, "_hold"}, {done, busy}, {1'b1, 1'b0});
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    clear_faults();
    repeat (2) @(negedge clk);
    chk("reset_outs", all_outs(), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", all_outs(), 64'h0);

    run_once("clean", 0, 1'b0);

    s_and[5] = 8'hF7;
    run_once("stuck5b3", 0, 1'b0);
    chk("stuck5b3_addr", fail_addr, 5);
    chk("stuck5b3_elem", fail_elem, 2);
    chk("stuck5b3_data", fail_data, 8'hF7);
    clear_faults();

    cpl_en = 1'b1; cpl_agg = 2; cpl_vic = 9;
    run_once("cpl2_9", 0, 1'b0);
    chk("cpl2_9_fail", pass, 1'b0);
    clear_faults();

    run_once("clean_after_fault", 0, 1'b0);
    run_once("abort", 50, 1'b0);
    run_once("after_abort", 0, 1'b0);
    run_once("repulse", 0, 1'b1);

    for (int i = 0; i < DEPTH; i++) s_and[i] = 8'h00;
    run_once("all_sa0", 0, 1'b0);
    chk("all_sa0_sat", err_count, EMAX);
    clear_faults();

    for (int r = 0; r < 6; r++) begin
      int a, b;
      a = $urandom_range(DEPTH - 1);
      b = $urandom_range(DW - 1);
      if ($urandom_range(1)) s_or[a][b] = 1'b1; else s_and[a][b] = 1'b0;
      if ($urandom_range(1)) begin
        cpl_en = 1'b1; cpl_agg = $urandom_range(DEPTH - 1);
        cpl_vic = (cpl_agg + 1 + $urandom_range(DEPTH - 2)) % DEPTH;
      end
      run_once("rand", 0, 1'b0);
      clear_faults();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
